// File: rtl/mac_accum.sv
// Windowed multiply-accumulate stage: sums N_TERMS signed 5-bit products per result with valid/ready on both sides.
// Optional MAC_ACCUM_SAT_EN clamps each addition to the ACC_W signed range instead of wrapping.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_ACCUM | collecting products of the current window, no result pending
// ST_HOLD  | completed sum presented on out_sum, waiting for out_ready
module mac_accum #(
    parameter int N_TERMS = 9,
    parameter int ACC_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    typedef enum logic {
        ST_ACCUM,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W:0]   add_wide;
    logic             add_oor;
    logic [ACC_W-1:0] add_res;
    logic             in_acc;

    assign in_ready  = (state_q == ST_ACCUM) | out_ready;
    assign out_valid = (state_q == ST_HOLD);
    assign in_acc    = in_valid & in_ready;
    assign out_sum   = sum_q;
    assign out_ovf   = out_ovf_q;

    // acc is zero in HOLD, so the same adder seeds the next window there.
    always_comb begin
        add_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W - 4){in_mul[4]}}, in_mul};
        add_oor  = add_wide[ACC_W] ^ add_wide[ACC_W-1];
`ifdef MAC_ACCUM_SAT_EN
        if (add_oor) begin
            add_res = add_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                      : {1'b0, {(ACC_W - 1){1'b1}}};
        end else begin
            add_res = add_wide[ACC_W-1:0];
        end
`else
        add_res = add_wide[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        out_ovf_d = out_ovf_q;

        if (clr) begin
            state_d   = ST_ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            ovf_d     = 1'b0;
            sum_d     = '0;
            out_ovf_d = 1'b0;
        end else if (in_acc) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_HOLD;
                sum_d     = add_res;
                out_ovf_d = ovf_q | add_oor;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end else begin
                // in HOLD an input accept implies the output was taken too
                state_d = ST_ACCUM;
                acc_d   = add_res;
                cnt_d   = cnt_q + CNT_W'(1);
                ovf_d   = ovf_q | add_oor;
            end
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed scenarios plus randomized windows against an integer reference model.
module tb_mac_accum;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_mul;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       out_ovf;

    logic       clr6;
    logic       in_valid6;
    logic       in_ready6;
    logic [4:0] in_mul6;
    logic       out_valid6;
    logic       out_ready6;
    logic [5:0] out_sum6;
    logic       out_ovf6;

    int checks = 0;
    int errors = 0;

    mac_accum #(.N_TERMS(9), .ACC_W(9)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_mul(in_mul),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    mac_accum #(.N_TERMS(9), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .clr(clr6),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_mul(in_mul6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .out_sum(out_sum6), .out_ovf(out_ovf6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One addition of the reference model: exact integer sum, range flag, then clamp or wrap.
    function automatic int ref_add(input int acc, input int x, input int w, inout bit o);
        int lo;
        int hi;
        int s;
        lo = -(1 << (w - 1));
        hi = (1 << (w - 1)) - 1;
        s  = acc + x;
        if (s < lo || s > hi) o = 1'b1;
`ifdef MAC_ACCUM_SAT_EN
        if (s < lo) s = lo;
        if (s > hi) s = hi;
`else
        s = (s - lo) % (1 << w);
        if (s < 0) s += (1 << w);
        s += lo;
`endif
        return s;
    endfunction

    task automatic drive(input bit v, input int mul, input bit ordy, input bit c);
        logic [31:0] m;
        m         = mul;
        in_valid  = v;
        in_mul    = m[4:0];
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_sum !== 9'd0)   begin errors++; $display("FAIL reset_out_sum got %h want 000", out_sum); end
        checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pos9();
        for (int i = 0; i < 9; i++) begin
            drive(1, 9, 1, 0);
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++; $display("FAIL pos9_accum i=%0d ready=%b valid=%b want 1 0", i, in_ready, out_valid);
            end
            tick();
        end
        drive(0, 0, 1, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pos9_valid got %b want 1", out_valid); end
        checks++; if (out_sum !== 9'h051) begin errors++; $display("FAIL pos9_sum got %h want 051", out_sum); end
        checks++; if (out_ovf !== 1'b0)   begin errors++; $display("FAIL pos9_ovf got %b want 0", out_ovf); end
        tick();
        drive(0, 0, 1, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pos9_drop got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) begin
            drive(1, -12, 1, 0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got %b want 1", i, in_ready); end
            checks++; if (out_valid !== (i == 9)) begin
                errors++; $display("FAIL b2b_valid i=%0d got %b want %b", i, out_valid, (i == 9));
            end
            if (i == 9) begin
                checks++; if (out_sum !== 9'h194) begin errors++; $display("FAIL b2b_sum1 got %h want 194", out_sum); end
            end
            tick();
        end
        drive(0, 0, 1, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 9'h194) begin
            errors++; $display("FAIL b2b_sum2 valid=%b sum=%h want 1 194", out_valid, out_sum);
        end
        tick();
        drive(0, 0, 1, 0);
        tick();
    endtask

    task automatic test_hold();
        for (int i = 0; i < 9; i++) begin
            drive(1, 3, 1, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0);
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 9'd27 || out_ovf !== 1'b0) begin
                errors++; $display("FAIL hold_stable i=%0d valid=%b ready=%b sum=%h ovf=%b want 1 0 01b 0",
                                   i, out_valid, in_ready, out_sum, out_ovf);
            end
            tick();
        end
        drive(1, 1, 1, 0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b want 1", in_ready); end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 9'd9) begin
            errors++; $display("FAIL hold_next_window valid=%b sum=%h want 1 009", out_valid, out_sum);
        end
        tick();
        drive(0, 0, 1, 0);
        tick();
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 4; i++) begin
            drive(1, 7, 1, 0);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #3;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 9'd0) begin
            errors++; $display("FAIL rst_mid_values ready=%b valid=%b sum=%h want 1 0 000", in_ready, out_valid, out_sum);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 1, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 9'd9) begin
            errors++; $display("FAIL rst_mid_sum valid=%b sum=%h want 1 009", out_valid, out_sum);
        end
        tick();
        drive(0, 0, 1, 0);
        tick();
    endtask

    task automatic test_clr();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5, 1, 0);
            tick();
        end
        drive(1, 5, 1, 1);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b1 || out_sum !== 9'd9 || out_ovf !== 1'b0) begin
            errors++; $display("FAIL clr_mid_sum valid=%b sum=%h ovf=%b want 1 009 0", out_valid, out_sum, out_ovf);
        end
        tick();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clr_hold_drop valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        tick();
    endtask

    task automatic test_narrow();
        int  e;
        bit  eo;
        logic [31:0] ev;
        e  = 0;
        eo = 1'b0;
        for (int i = 0; i < 9; i++) e = ref_add(e, 9, 6, eo);
        ev = e;
        for (int i = 0; i < 9; i++) begin
            in_valid6 = 1'b1;
            in_mul6   = 5'd9;
            tick();
        end
        in_valid6 = 1'b0;
        @(negedge clk);
        checks++; if (out_valid6 !== 1'b1) begin errors++; $display("FAIL narrow_valid got %b want 1", out_valid6); end
        checks++; if (out_sum6 !== ev[5:0]) begin errors++; $display("FAIL narrow_sum got %h want %h", out_sum6, ev[5:0]); end
        checks++; if (out_ovf6 !== eo) begin errors++; $display("FAIL narrow_ovf got %b want %b", out_ovf6, eo); end
        tick();
    endtask

    task automatic test_random();
        int  exp_s[$];
        bit  exp_o[$];
        int  m_acc;
        int  m_cnt;
        bit  m_ovf;
        int  got;
        int  cyc;
        int  mul;
        bit  v;
        bit  ordy;
        int  es;
        bit  eo;
        logic [31:0] ev;
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0; got = 0; cyc = 0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        while (got < 100 && cyc < 20000) begin
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            mul  = $urandom_range(0, 21) - 12;
            drive(v, mul, ordy, 0);
            checks++; if (in_ready !== (!out_valid || ordy)) begin
                errors++; $display("FAIL rand_ready cyc=%0d got %b valid=%b out_ready=%b", cyc, in_ready, out_valid, ordy);
            end
            if (out_valid && ordy) begin
                checks++;
                if (exp_s.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected cyc=%0d sum=%h want none", cyc, out_sum);
                end else begin
                    es = exp_s.pop_front();
                    eo = exp_o.pop_front();
                    ev = es;
                    if (out_sum !== ev[8:0] || out_ovf !== eo) begin
                        errors++; $display("FAIL rand_sum win=%0d got %h/%b want %h/%b", got, out_sum, out_ovf, ev[8:0], eo);
                    end
                end
                got++;
            end
            if (v && in_ready) begin
                m_acc = ref_add(m_acc, mul, 9, m_ovf);
                m_cnt++;
                if (m_cnt == 9) begin
                    exp_s.push_back(m_acc);
                    exp_o.push_back(m_ovf);
                    m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        checks++; if (got < 100) begin errors++; $display("FAIL rand_timeout windows got %0d want 100", got); end
        drive(0, 0, 1, 0);
        tick();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_mul = '0; out_ready = 1'b1;
        clr6 = 1'b0; in_valid6 = 1'b0; in_mul6 = '0; out_ready6 = 1'b1;
        #1;
        test_reset();
        test_pos9();
        test_back_to_back();
        test_hold();
        test_rst_mid();
        test_clr();
        test_narrow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
# mac_accum

Accumulator stage directly downstream of the 2-bit multiplier array in the MultiMultiplier path. Accepts one signed 5-bit partial product per cycle over a valid/ready handshake and sums a fixed number of terms (one kernel window). Presents the signed sum with a valid/ready output handshake. Supports back-to-back windows at full throughput.

## Interface
- `N_TERMS`, default 9: products summed per result (3x3 kernel); legal range 2..256.
- `ACC_W`, default 9: accumulator/result width in bits, two's complement; legal range 5..32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `clr` in 1: synchronous flush; abandons the partial sum and any pending result.
- `in_valid` in 1: `in_mul` holds a product.
- `in_ready` out 1: stage can take a product this cycle.
- `in_mul` in 5: multiplier product, two's complement, range -16..15 (-12..9 in practice).
- `out_valid` out 1: `out_sum` holds a completed window sum.
- `out_ready` in 1: consumer takes `out_sum` this cycle.
- `out_sum` out ACC_W: window sum, two's complement.
- `out_ovf` out 1: sticky per window; set if any addition in the window exceeded the ACC_W signed range.

## Operation
- Input accept: `in_valid & in_ready`. Output accept: `out_valid & out_ready`.
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `out_valid`=1, `in_ready`=`out_ready` (combinational path).
- Registers: `acc` (ACC_W), `cnt` (ceil(log2 N_TERMS) bits), `ovf`.
- Input accept in ACCUM: `acc <= acc + sext(in_mul)` (sign-extend to ACC_W+1, add, check range, reduce to ACC_W); `cnt <= cnt+1`; `ovf` ORs in the range check.
- Input accept with `cnt == N_TERMS-1`:
  - The completed sum loads `out_sum`, and the `ovf` result loads `out_ovf`.
  - `acc`, `cnt` and `ovf` clear to 0; state goes to HOLD.
- HOLD with output accept and no input accept: go to ACCUM.
- HOLD with both output accept and input accept: the new product starts the next window (`acc <= sext(in_mul)`, `cnt <= 1`); go to ACCUM.
- HOLD with `out_ready`=0: `out_sum` and `out_ovf` held stable; `in_ready`=0.
- N_TERMS-1 accept while in HOLD: not possible, because a window needs at least 2 accepts.
- `clr`: highest priority.
  - `acc`, `cnt`, `ovf` cleared; state goes to ACCUM; `out_valid` drops next cycle.
  - Any product offered in the `clr` cycle is accepted and discarded.
- `in_valid`=0 cycles are stalls; `acc` and `cnt` hold. No timeout.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_ovf`=0; state ACCUM; `acc`/`cnt`/`ovf`=0.
- Latency: `out_valid` rises on the first edge after the N_TERMS-th input accept.
- Throughput: one result per N_TERMS cycles when `in_valid`=1 and `out_ready`=1 continuously; no bubble between windows.
- `rst` asserted mid-window or mid-HOLD: immediate return to reset values; the partial window is lost.
- `out_sum` and `out_ovf` change only on the completion edge, on `clr`, or on `rst`; they are never glitched while `out_valid`=1.

## Configuration
- `MAC_ACCUM_SAT_EN` defined:
  - Each addition saturates to -2^(ACC_W-1) / 2^(ACC_W-1)-1.
  - Saturation is sticky: later terms add from the clamped value.
  - `out_ovf` flags any clamp.
- Undefined: additions wrap modulo 2^ACC_W; `out_ovf` still flags any out-of-range addition.

## Test plan
- Defaults, 9 products of +9 back-to-back, `out_ready`=1 -> `out_valid` one cycle after the 9th accept; `out_sum`=81 (9'h051); `out_ovf`=0.
- 9 products of -12 -> `out_sum`=-108 (9'h194). Then 9 more with no gap -> second result 9 cycles later; no bubble on `in_ready`.
- `out_ready`=0 for 5 cycles after completion -> `out_sum` held; `in_ready`=0; next-window products stall. Release -> accept resumes in the same cycle.
- ACC_W=6, 9 products of +9:
  - With macro: `out_sum`=31, `out_ovf`=1.
  - Without macro: `out_sum`=17 (81 mod 64), `out_ovf`=1.
- `rst` pulse after 4 accepts, then 9 products of +1 -> `out_sum`=9. Separately, `clr` after 4 accepts of +5, then 9 products of +1 -> `out_sum`=9.
- Random `in_valid`/`out_ready` gaps, 100 windows of random products in -12..9 -> every `out_sum` matches the reference-model sum.
